// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and widths for the main-memory request
//                arbiter. Defines the request type, the arbiter FSM state
//                encoding and the default block address/data types.
//                Supplies defaults for MAIN_MEM_BLOCK_ADDR_WIDTH and
//                BLOCK_DATA_WIDTH when the including build does not.
//  Revision    : 1.0 - initial release
// ============================================================================

`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 26
`endif

`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 512
`endif

package mem_ctrl_pkg;

    localparam int c_MAIN_MEM_BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH;
    localparam int c_BLOCK_DATA_WIDTH          = `BLOCK_DATA_WIDTH;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } mem_arb_state_t;

    typedef logic [c_MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;
    typedef logic [c_BLOCK_DATA_WIDTH-1:0]          block_data_t;

    // Width of a client index; a single client still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first
//                asserted request at or after rr_ptr, wrapping modulo N.
//  Ports       : req       [N]     request vector
//                rr_ptr    [IDX_W] highest-priority index this cycle
//                grant     [N]     one-hot grant (all zero if no request)
//                grant_idx [IDX_W] binary index of the granted request
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // One spare bit so ptr + offset can be compared against N before wrapping.
    localparam int c_SUM_W = IDX_W + 1;

    logic [c_SUM_W-1:0] w_sum;
    logic               w_found;

    always_comb begin
        w_sum     = '0;
        w_found   = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, rr_ptr} + c_SUM_W'(i);
            if (w_sum >= c_SUM_W'(N)) begin
                w_sum = w_sum - c_SUM_W'(N);
            end
            if (!w_found && req[w_sum[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                grant_idx = w_sum[IDX_W-1:0];
            end
        end
        grant = w_found ? (N'(1) << grant_idx) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_arbiter
//  Description : N-client main-memory request arbiter/sequencer. Accepts one
//                block read/write at a time with round-robin fairness, issues
//                it to the single memory port, waits for the response (or a
//                watchdog timeout) and returns it to the requesting client.
//  Ports       : client_req_*      per-client request (packed buses)
//                client_req_ready  one-hot accept pulse
//                client_resp_*     one-hot response pulse + shared data
//                mem_req_*/mem_resp_* downstream memory port
//                err_timeout       sticky watchdog flag
//                perf_grant_cnt / perf_wait_cycles  (MEM_CTRL_PERF_CNT_EN)
//  Config      : MEM_CTRL_PERF_CNT_EN adds saturating per-client grant and
//                wait-cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int N_CLIENTS        = 2,
    parameter int BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int BLOCK_DATA_WIDTH = `BLOCK_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES   = 256
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_CLIENTS-1:0]                  client_req_valid,
    input  logic [N_CLIENTS-1:0]                  client_req_type,
    input  logic [N_CLIENTS*BLOCK_ADDR_WIDTH-1:0] client_req_block_addr,
    input  logic [N_CLIENTS*BLOCK_DATA_WIDTH-1:0] client_req_block_data,
    output logic [N_CLIENTS-1:0]                  client_req_ready,
    output logic [N_CLIENTS-1:0]                  client_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0]           client_resp_block_data,
    output logic                                  mem_req_valid,
    output logic                                  mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0]           mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0]           mem_req_block_data,
    input  logic                                  mem_req_ready,
    input  logic                                  mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0]           mem_resp_block_data,
`ifdef MEM_CTRL_PERF_CNT_EN
    output logic [N_CLIENTS*32-1:0]               perf_grant_cnt,
    output logic [N_CLIENTS*32-1:0]               perf_wait_cycles,
`endif
    output logic                                  err_timeout
);

    localparam int c_IDX_W = idx_width(N_CLIENTS);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST    = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_CLIENT  = c_IDX_W'(N_CLIENTS - 1);

    mem_arb_state_t              r_state;
    mem_arb_state_t              w_state_nxt;
    logic [c_IDX_W-1:0]          r_rr_ptr;
    logic [c_IDX_W-1:0]          r_grant;
    req_type_t                   r_type;
    logic [BLOCK_ADDR_WIDTH-1:0] r_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_wdata;
    logic [BLOCK_DATA_WIDTH-1:0] r_rdata;
    logic [c_CNT_W-1:0]          r_wait_cnt;
    logic                        r_err;

    logic [N_CLIENTS-1:0]        w_arb_grant;
    logic [c_IDX_W-1:0]          w_arb_idx;
    logic                        w_accept;
    logic                        w_timeout;

    rr_arbiter #(
        .N     (N_CLIENTS),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .req       (client_req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (|client_req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    w_state_nxt = ST_RESP;
                end else if (r_wait_cnt == c_WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // The accept pulse is combinational from client valids, so it must be
    // masked explicitly while reset is held.
    assign client_req_ready       = (w_accept && !rst) ? w_arb_grant : '0;
    assign client_resp_valid      = (r_state == ST_RESP) ? (N_CLIENTS'(1) << r_grant) : '0;
    assign client_resp_block_data = r_rdata;
    assign mem_req_valid          = (r_state == ST_ISSUE);
    assign mem_req_type           = r_type;
    assign mem_req_block_addr     = r_addr;
    assign mem_req_block_data     = r_wdata;
    assign err_timeout            = r_err;

    // ------------------------------------------------------------------
    // Request latches, response data, watchdog and round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant    <= '0;
            r_type     <= READ;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_arb_idx;
                r_type  <= req_type_t'(client_req_type[w_arb_idx]);
                r_addr  <= client_req_block_addr[w_arb_idx*BLOCK_ADDR_WIDTH +: BLOCK_ADDR_WIDTH];
                r_wdata <= client_req_block_data[w_arb_idx*BLOCK_DATA_WIDTH +: BLOCK_DATA_WIDTH];
            end

            // The counter is cleared throughout ISSUE so WAIT always starts at 0.
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == ST_WAIT && !mem_resp_valid && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end

            if (r_state == ST_WAIT) begin
                if (mem_resp_valid) begin
                    r_rdata <= mem_resp_block_data;
                end else if (w_timeout) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
            end

            // Priority moves past the client just served; with one client
            // the comparison is always true and the pointer stays 0.
            if (r_state == ST_RESP) begin
                r_rr_ptr <= (r_grant == c_LAST_CLIENT) ? '0 : r_grant + c_IDX_W'(1);
            end
        end
    end

`ifdef MEM_CTRL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Per-client saturating performance counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_perf
        logic [31:0] r_grant_cnt;
        logic [31:0] r_wait_cyc;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_grant_cnt <= '0;
                r_wait_cyc  <= '0;
            end else begin
                if (client_req_ready[gi] && (r_grant_cnt != '1)) begin
                    r_grant_cnt <= r_grant_cnt + 32'd1;
                end
                if (client_req_valid[gi] && !client_req_ready[gi] && (r_wait_cyc != '1)) begin
                    r_wait_cyc <= r_wait_cyc + 32'd1;
                end
            end
        end

        assign perf_grant_cnt[gi*32 +: 32]   = r_grant_cnt;
        assign perf_wait_cycles[gi*32 +: 32] = r_wait_cyc;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_ctrl_arbiter
//  Description : Directed self-checking bench for mem_ctrl_arbiter with two
//                clients, 8-bit addresses, 32-bit data and an 8-cycle
//                watchdog. Exercises MEM_CTRL_PERF_CNT_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl_arbiter;

    localparam int c_N  = 2;
    localparam int c_AW = 8;
    localparam int c_DW = 32;
    localparam int c_TO = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_N-1:0]        req_valid;
    logic [c_N-1:0]        req_type;
    logic [c_N*c_AW-1:0]   req_addr;
    logic [c_N*c_DW-1:0]   req_data;
    logic [c_N-1:0]        req_ready;
    logic [c_N-1:0]        resp_valid;
    logic [c_DW-1:0]       resp_data;
    logic                  m_req_valid;
    logic                  m_req_type;
    logic [c_AW-1:0]       m_req_addr;
    logic [c_DW-1:0]       m_req_data;
    logic                  m_req_ready;
    logic                  m_resp_valid;
    logic [c_DW-1:0]       m_resp_data;
    logic                  err;
`ifdef MEM_CTRL_PERF_CNT_EN
    logic [c_N*32-1:0]     perf_grant;
    logic [c_N*32-1:0]     perf_wait;
`endif

    int checks = 0;
    int errors = 0;
    int g0     = 0;
    int g1     = 0;

    mem_ctrl_arbiter #(
        .N_CLIENTS        (c_N),
        .BLOCK_ADDR_WIDTH (c_AW),
        .BLOCK_DATA_WIDTH (c_DW),
        .TIMEOUT_CYCLES   (c_TO)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .client_req_valid       (req_valid),
        .client_req_type        (req_type),
        .client_req_block_addr  (req_addr),
        .client_req_block_data  (req_data),
        .client_req_ready       (req_ready),
        .client_resp_valid      (resp_valid),
        .client_resp_block_data (resp_data),
        .mem_req_valid          (m_req_valid),
        .mem_req_type           (m_req_type),
        .mem_req_block_addr     (m_req_addr),
        .mem_req_block_data     (m_req_data),
        .mem_req_ready          (m_req_ready),
        .mem_resp_valid         (m_resp_valid),
        .mem_resp_block_data    (m_resp_data),
`ifdef MEM_CTRL_PERF_CNT_EN
        .perf_grant_cnt         (perf_grant),
        .perf_wait_cycles       (perf_wait),
`endif
        .err_timeout            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction for a single client with immediate memory
    // accept and a one-cycle response. Starts and ends at an IDLE cycle.
    task automatic run_txn(input int c, input logic typ, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata);
        logic [1:0] oh;
        oh = 2'b01 << c;
        req_valid            = oh;
        req_type[c]          = typ;
        req_addr[c*8 +: 8]   = addr;
        req_data[c*32 +: 32] = wdata;
        #1 chk("txn_ready", req_ready, oh);
        tick();
        req_valid   = '0;
        m_req_ready = 1'b1;
        #1;
        chk("txn_mem_valid", m_req_valid, 1);
        chk("txn_mem_addr", m_req_addr, addr);
        chk("txn_mem_type", m_req_type, typ);
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = rdata;
        #1 chk("txn_wait_noresp", resp_valid, 0);
        tick();
        m_resp_valid = 1'b0;
        #1;
        chk("txn_resp_valid", resp_valid, oh);
        chk("txn_resp_data", resp_data, rdata);
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 2'b01;
        req_type     = '0;
        req_addr     = '0;
        req_data     = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_mem_valid", m_req_valid, 0);
        chk("rst_mem_type", m_req_type, 0);
        chk("rst_mem_addr", m_req_addr, 0);
        chk("rst_mem_data", m_req_data, 0);
        chk("rst_err", err, 0);
        rst       = 1'b0;
        req_valid = '0;

        // ---------------- minimum-latency read, client0 ----------------
        req_addr[7:0] = 8'h10;
        req_valid     = 2'b01;
        #1 chk("lat_ready_t", req_ready, 2'b01);
        chk("lat_memvalid_t", m_req_valid, 0);
        tick();
        req_valid   = '0;
        m_req_ready = 1'b1;
        #1 chk("lat_memvalid_t1", m_req_valid, 1);
        chk("lat_memaddr_t1", m_req_addr, 8'h10);
        chk("lat_memtype_t1", m_req_type, 0);
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hAAAA_AAAA;
        #1 chk("lat_memvalid_t2", m_req_valid, 0);
        chk("lat_resp_t2", resp_valid, 0);
        tick();
        m_resp_valid = 1'b0;
        #1 chk("lat_resp_t3", resp_valid, 2'b01);
        chk("lat_data_t3", resp_data, 32'hAAAA_AAAA);
        tick();
        #1 chk("lat_resp_t4", resp_valid, 0);

        // ---------------- round-robin alternation from reset ----------------
        rst = 1'b1;
        #1 rst = 1'b0;
        req_addr     = {8'h42, 8'h21};
        req_type     = 2'b00;
        req_valid    = 2'b11;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] oh;
            oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            #1 chk("rr_ready", req_ready, oh);
            if (req_ready[0]) g0++;
            if (req_ready[1]) g1++;
            tick();
            m_resp_data = 32'h1000 + k;
            #1 chk("rr_mem_addr", m_req_addr, (k % 2 == 0) ? 8'h21 : 8'h42);
            chk("rr_ready_busy", req_ready, 0);
            tick();
            #1 chk("rr_wait_noresp", resp_valid, 0);
            tick();
            #1 chk("rr_resp_valid", resp_valid, oh);
            chk("rr_resp_data", resp_data, 32'h1000 + k);
            tick();
        end
        req_valid    = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        chk("rr_grants_c0", g0, 2);
        chk("rr_grants_c1", g1, 2);

        // ---------------- client1 write with delayed memory accept ----------------
        req_type[1]      = 1'b1;
        req_addr[15:8]   = 8'h03;
        req_data[63:32]  = 32'h5555_5555;
        req_valid        = 2'b10;
        #1 chk("wr_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("wr_stall_valid", m_req_valid, 1);
            chk("wr_stall_type", m_req_type, 1);
            chk("wr_stall_addr", m_req_addr, 8'h03);
            chk("wr_stall_data", m_req_data, 32'h5555_5555);
            tick();
        end
        m_req_ready = 1'b1;
        #1 chk("wr_accept_valid", m_req_valid, 1);
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h1234_5678;
        #1 chk("wr_wait_memvalid", m_req_valid, 0);
        tick();
        m_resp_valid = 1'b0;
        #1 chk("wr_ack_valid", resp_valid, 2'b10);
        chk("wr_ack_data", resp_data, 32'h1234_5678);
        tick();
        #1 chk("wr_ack_once", resp_valid, 0);
        req_type = '0;

        // ---------------- watchdog timeout ----------------
        req_addr[7:0] = 8'h07;
        req_valid     = 2'b01;
        #1 chk("to_ready", req_ready, 2'b01);
        tick();
        req_valid   = '0;
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        for (int k = 1; k <= c_TO; k++) begin
            #1 chk("to_wait_noresp", resp_valid, 0);
            if (k < c_TO) chk("to_err_low", err, 0);
            tick();
        end
        #1 chk("to_err_high", err, 1);
        chk("to_resp_valid", resp_valid, 2'b01);
        chk("to_resp_data", resp_data, 0);
        tick();
        #1 chk("to_err_sticky", err, 1);
        run_txn(1, 1'b0, 8'h05, 32'h0, 32'hCAFE_F00D);
        #1 chk("to_err_sticky2", err, 1);

        // ---------------- reset while waiting ----------------
        run_txn(0, 1'b0, 8'h09, 32'h0, 32'h0BAD_0001);
        req_valid = 2'b11;
        #1 chk("rw_ready_ptr1", req_ready, 2'b10);
        tick();
        req_valid   = '0;
        m_req_ready = 1'b1;
        tick();
        m_req_ready = 1'b0;
        rst         = 1'b1;
        #1 chk("rw_rst_memvalid", m_req_valid, 0);
        chk("rw_rst_resp", resp_valid, 0);
        chk("rw_rst_err", err, 0);
        chk("rw_rst_addr", m_req_addr, 0);
        tick();
        rst          = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'hDEAD_BEEF;
        #1 chk("rw_stray_resp0", resp_valid, 0);
        tick();
        m_resp_valid = 1'b0;
        #1 chk("rw_stray_resp1", resp_valid, 0);
        chk("rw_idle_memvalid", m_req_valid, 0);
        tick();
        #1 chk("rw_stray_resp2", resp_valid, 0);
        req_valid = 2'b11;
        #1 chk("rw_ptr_reset", req_ready, 2'b01);
        tick();
        req_valid   = '0;
        m_req_ready = 1'b1;
        #1 chk("rw_issue_addr", m_req_addr, 8'h09);
        tick();
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h0000_0077;
        tick();
        m_resp_valid = 1'b0;
        #1 chk("rw_resp_valid", resp_valid, 2'b01);
        chk("rw_resp_data", resp_data, 32'h0000_0077);
        tick();

`ifdef MEM_CTRL_PERF_CNT_EN
        // ---------------- performance counters ----------------
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk("perf_rst_grant", perf_grant, 0);
        chk("perf_rst_wait", perf_wait, 0);
        req_valid    = 2'b11;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
        end
        req_valid    = '0;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        #1 chk("perf_grant_cnt", perf_grant, {32'd1, 32'd2});
        chk("perf_wait_c1_nonzero", (perf_wait[63:32] != 32'd0), 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
Parametrised N-client main-memory request arbiter and sequencer sitting between the core's cache memory-controller ports (icache, dcache, future L2/prefetch clients) and the single main-memory port. It accepts block read/write requests with round-robin fairness and keeps one transaction outstanding. It routes each response back to the requesting client and flags hung memory via a watchdog.

Parameters:
N_CLIENTS, 2, number of requesting clients (>=1)
BLOCK_ADDR_WIDTH, `MAIN_MEM_BLOCK_ADDR_WIDTH, block address width
BLOCK_DATA_WIDTH, `BLOCK_DATA_WIDTH, block data width
TIMEOUT_CYCLES, 256, max WAIT cycles before watchdog fires (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
client_req_valid  in  N_CLIENTS  per-client request valid
client_req_type  in  N_CLIENTS  per-client type, 0 read / 1 write
client_req_block_addr  in  N_CLIENTS*BLOCK_ADDR_WIDTH  packed per-client address
client_req_block_data  in  N_CLIENTS*BLOCK_DATA_WIDTH  packed per-client write data
client_req_ready  out  N_CLIENTS  one-hot accept pulse
client_resp_valid  out  N_CLIENTS  one-hot response pulse
client_resp_block_data  out  BLOCK_DATA_WIDTH  response data, shared by all clients
mem_req_valid  out  1  downstream request valid
mem_req_type  out  1  downstream type
mem_req_block_addr  out  BLOCK_ADDR_WIDTH  downstream address
mem_req_block_data  out  BLOCK_DATA_WIDTH  downstream write data
mem_req_ready  in  1  downstream accept
mem_resp_valid  in  1  downstream response valid (reads and write acks)
mem_resp_block_data  in  BLOCK_DATA_WIDTH  downstream read data
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: state=IDLE, rr_ptr=0, wait_cnt=0, latched request and data regs = 0, err_timeout=0. All outputs are 0 during and after reset. Reset mid-transaction abandons the transaction; a later stray mem_resp_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any client_req_valid is set, grant the first valid client at or after rr_ptr (wrapping modulo N_CLIENTS). client_req_ready[grant]=1 combinationally in the same cycle. Latch type, addr, data and grant; go to ISSUE. With no valid requests, stay in IDLE.
- ISSUE: mem_req_* driven from the latches, held stable. When mem_req_ready=1, go to WAIT with wait_cnt=0.
- WAIT: mem_req_valid=0. On mem_resp_valid=1, latch mem_resp_block_data and go to RESP. Otherwise wait_cnt++. If wait_cnt reaches TIMEOUT_CYCLES-1 with no response, set err_timeout (sticky until rst), latch zero data and go to RESP.
- RESP: client_resp_valid[grant]=1 for exactly one cycle; client_resp_block_data = latched data. rr_ptr <= (grant+1) mod N_CLIENTS. Return to IDLE.
- Writes follow the same path; the response pulse is the write ack and its data is the memory's value (don't-care to clients).
- mem_resp_valid outside WAIT is ignored.
- Minimum latency: accept at cycle t → mem_req_valid at t+1. If mem_req_ready=1 at t+1 and mem_resp_valid=1 at t+2, client_resp_valid is asserted at t+3.
- Back-to-back transactions: the earliest next grant is the cycle after RESP. The throughput bound is 1 transaction per 4 cycles.
- Client contract: req fields must be held stable while valid until ready is seen. Clients may drop valid without penalty.
- N_CLIENTS=1: rr_ptr is constant 0.

Optional Feature:
MEM_CTRL_PERF_CNT_EN: when defined, the block adds output perf_grant_cnt (N_CLIENTS*32, counts grants per client) and output perf_wait_cycles (N_CLIENTS*32, counts cycles a client is valid but not granted). Both counters reset to 0 and saturate at 2^32-1. When the macro is undefined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Decomposition:
- Package mem_ctrl_pkg:
  - req_type_t (READ=0, WRITE=1)
  - mem_arb_state_t enum
  - main_mem_block_addr_t, block_data_t
- Sub-module rr_arbiter:
  - parametrised N, combinational
  - inputs: req vector, rr_ptr
  - outputs: one-hot grant and grant index
  - reusable by future issue-port arbitration

Test Plan:
- N=2, client0 read addr 0x10, mem_req_ready=1 immediately, resp data 0xAA..AA the next cycle → client_req_ready[0] at t, mem_req_valid at t+1, client_resp_valid=2'b01 with 0xAA..AA at t+3.
- Both clients valid continuously from reset → grants alternate 0,1,0,1; each client gets exactly 2 of 4 grants.
- Client1 write addr 0x3, data 0x55..55, mem_req_ready held low 5 cycles → mem_req fields stable all 5 cycles; client_resp_valid=2'b10 one cycle after the ack.
- TIMEOUT_CYCLES=8, no mem_resp_valid → err_timeout rises at WAIT cycle 8 and stays high; client_resp_valid pulses with data 0; next request still serviced.
- rst asserted during WAIT, then mem_resp_valid pulsed after release → no client_resp_valid; state IDLE; rr_ptr=0.
- With MEM_CTRL_PERF_CNT_EN and both clients valid for 3 transactions → perf_grant_cnt={1,2} (client1, client0); perf_wait_cycles nonzero for the losing client.
